tap_scan_driver: RTL and testbench
==================================

Name: tap_scan_driver

Overview:
- Host-side initiator for the user-DR JTAG scan path; it is the transmitter counterpart to the TAP byte decoder and the receiver of the TAP result encoder.
- Converts a command stream (write word / read word) into cycle-accurate TAP state strobes plus TDI bits, and reassembles TDO bits into result words.
- Used in the loopback/self-test harness and simulation top to drive the user logic exactly as a JTAG probe would.

Parameters:
- WRITE_WIDTH, 8, bits shifted per write scan (matches the inbound byte width).
- READ_WIDTH, 16, bits shifted per read scan (matches the result width).
- IDLE_GAP, 1, minimum IDLE cycles between scans (≥1).

Ports:
- tck  in  1  clock; all logic on rising edge.
- test_logic_reset  in  1  synchronous active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_read  in  1  1 = read scan, 0 = write scan.
- cmd_data  in  WRITE_WIDTH  write payload; ignored for reads.
- tdi  out  1  serial data to the DUT.
- tdo  in  1  serial data from the DUT.
- ir_is_user  out  1  user instruction selected.
- run_test_idle  out  1  TAP in Run-Test/Idle.
- capture_dr  out  1  Capture-DR strobe.
- shift_dr  out  1  Shift-DR strobe.
- update_dr  out  1  Update-DR strobe.
- rsp_valid  out  1  one-cycle pulse; read result available.
- rsp_data  out  READ_WIDTH  read result; holds its value until the next rsp_valid.

Behaviour:
- Reset values: cmd_ready=0, tdi=0, ir_is_user=0, run_test_idle=0, capture_dr=0, shift_dr=0, update_dr=0, rsp_valid=0, rsp_data=0. Reset is honoured in any state and aborts a scan mid-flight: no update_dr and no rsp_valid for the aborted scan.
- FSM states: RESET -> IDLE -> CAPTURE -> SHIFT -> EXIT -> UPDATE -> IDLE. RESET lasts one cycle after reset deasserts; ir_is_user=1 in every non-RESET state.
- All strobe outputs are registered and decoded one-hot from the state.
- IDLE: run_test_idle=1, all other strobes 0, tdi=0. cmd_ready=1 once IDLE_GAP IDLE cycles have elapsed.
  - On accept: latch cmd_read; latch cmd_data into the shift register; load the bit counter with WRITE_WIDTH-1 or READ_WIDTH-1; go to CAPTURE.
- CAPTURE: capture_dr=1 for exactly one cycle.
- SHIFT: shift_dr=1 for exactly N cycles (N = WRITE_WIDTH or READ_WIDTH).
  - Write: tdi = payload bit k in shift cycle k, LSB first.
  - Read: tdi=0. tdo is sampled on the rising edge that ends shift cycle k and stored as result bit k, LSB first (shift right, insert at MSB).
  - The counter decrements each cycle; leave SHIFT after the cycle in which the counter is 0.
- EXIT: all strobes 0 for one cycle (Exit1-DR).
- UPDATE: update_dr=1 for one cycle. For reads, rsp_valid=1 and rsp_data = assembled word, both in this same cycle.
- Latency with command accepted at edge 0:
  - CAPTURE at cycle 1.
  - SHIFT at cycles 2..N+1.
  - EXIT at cycle N+2.
  - UPDATE at cycle N+3.
  - IDLE from cycle N+4.
  - Earliest next accept at cycle N+3+IDLE_GAP.
- cmd_* inputs are ignored outside an accepted handshake. cmd_data changing during a scan has no effect.
- Write scans never modify rsp_data.
- tdo is ignored outside read SHIFT cycles.

Test Plan:
- Reset release: hold test_logic_reset for 3 cycles, then release -> all outputs 0 during reset; RESET for 1 cycle; then run_test_idle=1, ir_is_user=1, cmd_ready=1 after 1 IDLE cycle.
- Write 0x41 accepted at cycle 0 -> capture_dr at 1; shift_dr at 2..9 with tdi sequence 1,0,0,0,0,0,1,0; EXIT at 10; update_dr at 11; no rsp_valid.
- Read with the bench driving tdo from 0x1234 LSB first (0,0,1,0,1,1,0,0,0,1,0,0,1,0,0,0) in cycles 2..17 -> update_dr and rsp_valid at cycle 19, rsp_data=0x1234, tdi=0 throughout.
- Back-to-back: cmd_valid held high for writes 0x0A then 0x0B -> second accept at cycle 12; its capture_dr at 13; exactly one IDLE cycle between the scans.
- Abort: assert test_logic_reset during shift cycle 5 of a read -> outputs return to reset values at the next edge; no update_dr or rsp_valid; rsp_data=0; the next read completes normally.
- Write after read: read 0xBEEF, then write 0xFF -> rsp_data stays 0xBEEF after the write; rsp_valid pulses exactly once.

Source files
------------

// File: rtl/tap_scan_driver.sv
// tap_scan_driver: host-side JTAG user-DR scan initiator.
// Turns write/read word commands into TAP state strobes, drives TDI
// and reassembles TDO bits into read results.
//
// Ports:
//   tck, test_logic_reset            clock, synchronous active-high reset
//   cmd_valid/cmd_ready              command handshake
//   cmd_read, cmd_data               scan type and write payload
//   tdi, tdo                         serial data to / from the user logic
//   ir_is_user, run_test_idle        TAP status (registered)
//   capture_dr, shift_dr, update_dr  DR strobes (registered, one-hot)
//   rsp_valid, rsp_data              read result pulse and held value
module tap_scan_driver #(
    parameter int WRITE_WIDTH = 8,
    parameter int READ_WIDTH  = 16,
    parameter int IDLE_GAP    = 1
) (
    input  logic                   tck,
    input  logic                   test_logic_reset,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_read,
    input  logic [WRITE_WIDTH-1:0] cmd_data,
    output logic                   tdi,
    input  logic                   tdo,
    output logic                   ir_is_user,
    output logic                   run_test_idle,
    output logic                   capture_dr,
    output logic                   shift_dr,
    output logic                   update_dr,
    output logic                   rsp_valid,
    output logic [READ_WIDTH-1:0]  rsp_data
);

    localparam int MAXW = (WRITE_WIDTH > READ_WIDTH) ? WRITE_WIDTH
                                                     : READ_WIDTH;
    localparam int CW   = $clog2(MAXW + 1);
    localparam int GW   = $clog2(IDLE_GAP + 1);

    typedef enum logic [2:0] {
        S_RESET,
        S_IDLE,
        S_CAPTURE,
        S_SHIFT,
        S_EXIT,
        S_UPDATE
    } state_t;

    state_t                 state;
    logic                   is_read;
    logic [CW-1:0]          cnt;
    logic [GW-1:0]          idle_cnt;
    logic [WRITE_WIDTH-1:0] wsr;
    logic [READ_WIDTH-1:0]  rsr;

    always_ff @(posedge tck) begin
        if (test_logic_reset) begin
            state         <= S_RESET;
            is_read       <= 1'b0;
            cnt           <= '0;
            idle_cnt      <= '0;
            wsr           <= '0;
            rsr           <= '0;
            cmd_ready     <= 1'b0;
            tdi           <= 1'b0;
            ir_is_user    <= 1'b0;
            run_test_idle <= 1'b0;
            capture_dr    <= 1'b0;
            shift_dr      <= 1'b0;
            update_dr     <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_data      <= '0;
        end else begin
            rsp_valid <= 1'b0;
            unique case (state)
                S_RESET: begin
                    state         <= S_IDLE;
                    ir_is_user    <= 1'b1;
                    run_test_idle <= 1'b1;
                    idle_cnt      <= GW'(1);
                    cmd_ready     <= (IDLE_GAP <= 1);
                end
                S_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        state         <= S_CAPTURE;
                        is_read       <= cmd_read;
                        wsr           <= cmd_data;
                        cnt           <= cmd_read ? CW'(READ_WIDTH - 1)
                                                  : CW'(WRITE_WIDTH - 1);
                        cmd_ready     <= 1'b0;
                        run_test_idle <= 1'b0;
                        capture_dr    <= 1'b1;
                    end else if (idle_cnt < GW'(IDLE_GAP)) begin
                        // Count IDLE cycles until the minimum gap is met.
                        idle_cnt  <= idle_cnt + GW'(1);
                        cmd_ready <= (idle_cnt + GW'(1) >= GW'(IDLE_GAP));
                    end
                end
                S_CAPTURE: begin
                    state      <= S_SHIFT;
                    capture_dr <= 1'b0;
                    shift_dr   <= 1'b1;
                    tdi        <= !is_read && wsr[0];
                    wsr        <= wsr >> 1;
                end
                S_SHIFT: begin
                    // The edge ending each shift cycle captures tdo.
                    if (is_read) begin
                        rsr <= {tdo, rsr[READ_WIDTH-1:1]};
                    end
                    if (cnt == '0) begin
                        state    <= S_EXIT;
                        shift_dr <= 1'b0;
                        tdi      <= 1'b0;
                    end else begin
                        cnt <= cnt - CW'(1);
                        tdi <= !is_read && wsr[0];
                        wsr <= wsr >> 1;
                    end
                end
                S_EXIT: begin
                    state     <= S_UPDATE;
                    update_dr <= 1'b1;
                    if (is_read) begin
                        rsp_valid <= 1'b1;
                        rsp_data  <= rsr;
                    end
                end
                S_UPDATE: begin
                    state         <= S_IDLE;
                    update_dr     <= 1'b0;
                    run_test_idle <= 1'b1;
                    idle_cnt      <= GW'(1);
                    cmd_ready     <= (IDLE_GAP <= 1);
                end
                default: begin
                    state <= S_RESET;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tap_scan_driver.sv
// tb_tap_scan_driver: self-checking bench for tap_scan_driver.
// Directed and random scans checked against a cycle-phase model.
module tb_tap_scan_driver;

    localparam int W   = 8;
    localparam int R   = 16;
    localparam int GAP = 1;

    logic          tck = 1'b0;
    logic          test_logic_reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_read;
    logic [W-1:0]  cmd_data;
    logic          tdi;
    logic          tdo;
    logic          ir_is_user;
    logic          run_test_idle;
    logic          capture_dr;
    logic          shift_dr;
    logic          update_dr;
    logic          rsp_valid;
    logic [R-1:0]  rsp_data;

    int tests = 0;
    int fails = 0;

    // Model state: IDLE cycles seen since the last scan, last read word.
    int           idle_n;
    logic [R-1:0] exp_rsp;

    tap_scan_driver #(
        .WRITE_WIDTH (W),
        .READ_WIDTH  (R),
        .IDLE_GAP    (GAP)
    ) dut (
        .tck              (tck),
        .test_logic_reset (test_logic_reset),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_read         (cmd_read),
        .cmd_data         (cmd_data),
        .tdi              (tdi),
        .tdo              (tdo),
        .ir_is_user       (ir_is_user),
        .run_test_idle    (run_test_idle),
        .capture_dr       (capture_dr),
        .shift_dr         (shift_dr),
        .update_dr        (update_dr),
        .rsp_valid        (rsp_valid),
        .rsp_data         (rsp_data)
    );

    always #5 tck = ~tck;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] outs();
        return {cmd_ready, tdi, ir_is_user, run_test_idle,
                capture_dr, shift_dr, update_dr, rsp_valid};
    endfunction

    // Hold reset for n cycles, expecting every output at zero.
    task automatic reset_cycles(input int n);
        test_logic_reset = 1'b1;
        cmd_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge tck);
            chk("reset_outs", 32'(outs()), 32'h0);
            chk("reset_rsp", 32'(rsp_data), 32'h0);
        end
        test_logic_reset = 1'b0;
        idle_n  = 0;
        exp_rsp = '0;
    endtask

    // One scan: wait out the IDLE gap, issue the command, then check
    // every phase. abort_p > 0 asserts reset after checking that phase.
    task automatic run_cmd(input bit rd, input logic [W-1:0] wdata,
                           input logic [R-1:0] tword, input bit keep,
                           input int abort_p);
        int  n;
        bit  rdy;
        logic [7:0] e;
        n = rd ? R : W;
        rdy = 1'b0;
        for (int g = 0; g < GAP + 4 && !rdy; g++) begin
            @(negedge tck);
            idle_n++;
            rdy = (idle_n >= GAP);
            chk("idle_outs", 32'(outs()), {24'h0, rdy, 7'b0110000});
            chk("idle_rsp", 32'(rsp_data), 32'(exp_rsp));
            tdo = 1'($urandom);
            if (rdy) begin
                cmd_valid = 1'b1;
                cmd_read  = rd;
                cmd_data  = wdata;
            end
        end
        if (!rdy) begin
            chk("ready_timeout", 32'h0, 32'h1);
            return;
        end
        for (int p = 1; p <= n + 3; p++) begin
            @(negedge tck);
            e = 8'b0010_0000;
            if (p == 1) e[3] = 1'b1;
            if (p >= 2 && p <= n + 1) begin
                e[2] = 1'b1;
                e[6] = !rd && wdata[p-2];
            end
            if (p == n + 3) begin
                e[1] = 1'b1;
                e[0] = rd;
                if (rd) exp_rsp = tword;
            end
            chk(rd ? "read_outs" : "write_outs", 32'(outs()), 32'(e));
            chk("scan_rsp", 32'(rsp_data), 32'(exp_rsp));
            // Inputs outside the handshake are scrambled; must be ignored.
            cmd_valid = keep;
            cmd_read  = 1'($urandom);
            cmd_data  = W'($urandom);
            if (rd && p >= 2 && p <= n + 1) tdo = tword[p-2];
            else tdo = 1'($urandom);
            if (p == abort_p) begin
                test_logic_reset = 1'b1;
                return;
            end
        end
        idle_n = 0;
    endtask

    initial begin
        test_logic_reset = 1'b1;
        cmd_valid = 1'b0;
        cmd_read  = 1'b0;
        cmd_data  = '0;
        tdo       = 1'b0;
        idle_n    = 0;
        exp_rsp   = '0;

        reset_cycles(3);
        run_cmd(1'b0, 8'h41, 16'h0, 1'b0, 0);
        run_cmd(1'b1, 8'h00, 16'h1234, 1'b0, 0);
        run_cmd(1'b0, 8'h0A, 16'h0, 1'b1, 0);
        run_cmd(1'b0, 8'h0B, 16'h0, 1'b0, 0);
        // Abort during shift cycle 5 of a read (phase 2 + 5).
        run_cmd(1'b1, 8'h00, 16'hA5C3, 1'b0, 7);
        reset_cycles(2);
        run_cmd(1'b1, 8'h00, 16'h5A3C, 1'b0, 0);
        run_cmd(1'b1, 8'h00, 16'hBEEF, 1'b0, 0);
        run_cmd(1'b0, 8'hFF, 16'h0, 1'b0, 0);

        for (int i = 0; i < 24; i++) begin
            run_cmd(1'($urandom), W'($urandom), R'($urandom),
                    1'($urandom), 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
